// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit (radix-2 shift-add multiply, restoring divide).
// Optional: define MULDIV_FAST_MUL_EN to resolve all multiplies in one cycle with a combinational 2*XLEN multiplier.
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            START,
   input  logic [2:0]      FUNC3,
   input  logic [XLEN-1:0] OPERAND_A,
   input  logic [XLEN-1:0] OPERAND_B,
   input  logic            KILL,
   output logic            BUSYWAIT,
   output logic            DONE,
   output logic [XLEN-1:0] RESULT
);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_MUL  = 3'd1;
   localparam logic [2:0] S_DIV  = 3'd2;
   localparam logic [2:0] S_FIX  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);

   // Sign-correct a magnitude product and pick the low (MUL) or high (MULH*) half.
   function automatic logic [XLEN-1:0] fn_mul_sel(input logic [2*XLEN-1:0] prod,
                                                  input logic neg, input logic sel_lo);
      logic [2*XLEN-1:0] v;
      v = neg ? -prod : prod;
      if (sel_lo) return v[XLEN-1:0];
      else        return v[2*XLEN-1:XLEN];
   endfunction

   logic [2:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_func3;
   logic              r_neg_res;
   logic              r_neg_rem;
   logic [XLEN-1:0]   r_mag_a;
   logic [XLEN-1:0]   r_mag_b;
   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_rem;
   logic [XLEN-1:0]   r_quo;
   logic [XLEN-1:0]   r_result;

   logic              w_a_signed, w_b_signed, w_a_neg, w_b_neg;
   logic [XLEN-1:0]   w_mag_a, w_mag_b;
   logic              w_accept, w_div_zero, w_overflow;
   logic [XLEN-1:0]   w_special_res;
   logic [XLEN:0]     w_mul_sum;
   logic [XLEN:0]     w_trial;
   logic              w_ge;
   logic [XLEN-1:0]   w_diff, w_quo_fix, w_rem_fix;

   assign w_a_signed = (FUNC3 == 3'b001) | (FUNC3 == 3'b010) | (FUNC3 == 3'b100) | (FUNC3 == 3'b110);
   assign w_b_signed = (FUNC3 == 3'b001) | (FUNC3 == 3'b100) | (FUNC3 == 3'b110);
   assign w_a_neg    = w_a_signed & OPERAND_A[XLEN-1];
   assign w_b_neg    = w_b_signed & OPERAND_B[XLEN-1];
   assign w_mag_a    = w_a_neg ? -OPERAND_A : OPERAND_A;
   assign w_mag_b    = w_b_neg ? -OPERAND_B : OPERAND_B;

   assign w_accept   = (r_state == S_IDLE) & START & ~KILL;
   assign w_div_zero = FUNC3[2] & (OPERAND_B == {XLEN{1'b0}});
   assign w_overflow = FUNC3[2] & ~FUNC3[0]
                     & (OPERAND_A == {1'b1, {(XLEN-1){1'b0}}})
                     & (OPERAND_B == {XLEN{1'b1}});
   assign w_special_res = w_div_zero ? (FUNC3[1] ? OPERAND_A : {XLEN{1'b1}})
                                     : (FUNC3[1] ? {XLEN{1'b0}} : OPERAND_A);

   // One shift-add step: the multiplier sits in the low half and drains out as the product fills in.
   assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mag_a} : {(XLEN+1){1'b0}});

   // Trial remainder is XLEN+1 bits; when its top bit is set it always exceeds the divisor.
   assign w_trial   = {r_rem, r_quo[XLEN-1]};
   assign w_ge      = w_trial[XLEN] | (w_trial[XLEN-1:0] >= r_mag_b);
   assign w_diff    = w_trial[XLEN-1:0] - r_mag_b;
   assign w_quo_fix = r_neg_res ? -r_quo : r_quo;
   assign w_rem_fix = r_neg_rem ? -r_rem : r_rem;

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] w_fast_prod;
   assign w_fast_prod = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
`endif

   assign BUSYWAIT = w_accept | (r_state == S_MUL) | (r_state == S_DIV) | (r_state == S_FIX);
   assign DONE     = (r_state == S_DONE);
   assign RESULT   = r_result;

   // Operation sequencer and datapath registers.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state   <= S_IDLE;
         r_cnt     <= {CNT_W{1'b0}};
         r_func3   <= 3'b000;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_mag_a   <= {XLEN{1'b0}};
         r_mag_b   <= {XLEN{1'b0}};
         r_acc     <= {(2*XLEN){1'b0}};
         r_rem     <= {XLEN{1'b0}};
         r_quo     <= {XLEN{1'b0}};
         r_result  <= {XLEN{1'b0}};
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_func3   <= FUNC3;
                  r_neg_res <= w_a_neg ^ w_b_neg;
                  r_neg_rem <= w_a_neg;
                  r_cnt     <= CNT_INIT;
                  r_mag_a   <= w_mag_a;
                  r_mag_b   <= w_mag_b;
                  r_acc     <= {{XLEN{1'b0}}, w_mag_b};
                  r_rem     <= {XLEN{1'b0}};
                  r_quo     <= w_mag_a;
                  if (w_div_zero | w_overflow) begin
                     r_result <= w_special_res;
                     r_state  <= S_DONE;
                  end
`ifdef MULDIV_FAST_MUL_EN
                  else if (!FUNC3[2]) begin
                     r_result <= fn_mul_sel(w_fast_prod, w_a_neg ^ w_b_neg, FUNC3[1:0] == 2'b00);
                     r_state  <= S_DONE;
                  end
`endif
                  else begin
                     r_state <= FUNC3[2] ? S_DIV : S_MUL;
                  end
               end
            end
            S_MUL: begin
               if (KILL) begin
                  r_state <= S_IDLE;
               end else begin
                  r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
                  r_cnt <= r_cnt - CNT_ONE;
                  if (r_cnt == CNT_ONE) r_state <= S_FIX;
               end
            end
            S_DIV: begin
               if (KILL) begin
                  r_state <= S_IDLE;
               end else begin
                  r_rem <= w_ge ? w_diff : w_trial[XLEN-1:0];
                  r_quo <= {r_quo[XLEN-2:0], w_ge};
                  r_cnt <= r_cnt - CNT_ONE;
                  if (r_cnt == CNT_ONE) r_state <= S_FIX;
               end
            end
            S_FIX: begin
               if (KILL) begin
                  r_state <= S_IDLE;
               end else begin
                  if (r_func3[2]) r_result <= r_func3[1] ? w_rem_fix : w_quo_fix;
                  else            r_result <= fn_mul_sel(r_acc, r_neg_res, r_func3[1:0] == 2'b00);
                  r_state <= S_DONE;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
